// File: rtl/control_unit_pkg.sv
// Shared definitions for the LEGv8-subset multi-cycle control unit.
// Holds the control-word layout, ALU function codes, sequencer state
// encodings, opcode constants, the immediate-format selector and the
// branch-condition evaluator used by the decoder.
package control_unit_pkg;

  // MSB index of the control word (width CUL+1).
  localparam int CUL = 36;

  // Control-word field positions, for datapath consumers that slice the
  // flat word rather than using ctrl_word_t.
  localparam int CW_PS_LSB  = 35;
  localparam int CW_DA_LSB  = 30;
  localparam int CW_SA_LSB  = 25;
  localparam int CW_SB_LSB  = 20;
  localparam int CW_FS_LSB  = 15;
  localparam int CW_REGW    = 14;
  localparam int CW_RAMW    = 13;
  localparam int CW_EN_RAM  = 12;
  localparam int CW_EN_ALU  = 11;
  localparam int CW_BSEL    = 10;
  localparam int CW_PCSEL   = 9;
  localparam int CW_SL      = 8;
  localparam int CW_IRLOAD  = 7;

  // Sequencer state; the register is 4 bits wide, only two codes are legal.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_EXECUTE = 4'd1
  } state_t;

  // PC select.
  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_REG  = 2'b10;
  localparam logic [1:0] PS_REL  = 2'b11;

  // ALU function select.
  localparam logic [4:0] FS_AND   = 5'b00000;
  localparam logic [4:0] FS_ORR   = 5'b00100;
  localparam logic [4:0] FS_ADD   = 5'b01000;
  localparam logic [4:0] FS_SUB   = 5'b01001;
  localparam logic [4:0] FS_EOR   = 5'b01100;
  localparam logic [4:0] FS_PASSB = 5'b10100;

  // Field order matches CW_* positions above, MSB first.
  typedef struct packed {
    logic [1:0] ps;
    logic [4:0] da;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] fs;
    logic       reg_w;
    logic       ram_w;
    logic       en_ram;
    logic       en_alu;
    logic       b_sel;
    logic       pc_sel;
    logic       sl;
    logic       ir_load;
    logic [6:0] rsvd;
  } ctrl_word_t;

  // DP register opcodes, IR[31:21].
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_ANDS = 11'b11101010000;

  // DP immediate opcodes, IR[31:22].
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [9:0]  OP_ADDIS = 10'b1011000100;
  localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
  localparam logic [9:0]  OP_SUBIS = 10'b1111000100;

  // Remaining classes, each compared against its own IR prefix.
  localparam logic [8:0]  OP_MOVZ  = 9'b110100101;     // IR[31:23]
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;  // IR[31:21]
  localparam logic [10:0] OP_STUR  = 11'b11111000000;  // IR[31:21]
  localparam logic [5:0]  OP_B     = 6'b000101;        // IR[31:26]
  localparam logic [10:0] OP_BR    = 11'b11010110000;  // IR[31:21]
  localparam logic [7:0]  OP_BCOND = 8'b01010100;      // IR[31:24]

  // Which immediate format drives k.
  typedef enum logic [2:0] {
    K_ZERO,
    K_IMM12,
    K_IMM9,
    K_IMM26,
    K_IMM19,
    K_MOVW
  } k_sel_t;

  // Branch condition against flags {N,Z,C,V}. Codes 1000/1001 are
  // deliberately "never" in this subset; 1110/1111 are "always".
  function automatic logic cond_holds(input logic [3:0] cond,
                                      input logic [3:0] flags);
    logic n, z, c, v, r;
    {n, z, c, v} = flags;
    case (cond)
      4'b0000: r = z;
      4'b0001: r = !z;
      4'b0010: r = c;
      4'b0011: r = !c;
      4'b0100: r = n;
      4'b0101: r = !n;
      4'b0110: r = v;
      4'b0111: r = !v;
      4'b1000,
      4'b1001: r = 1'b0;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = !z && (n == v);
      4'b1101: r = z || (n != v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bus between the IR/status registers and the datapath on one side and
// the control unit on the other.
//   IR          instruction register contents
//   status      ALU flags {N,Z,C,V}
//   controlWord datapath control word
//   k           immediate constant
// master: the datapath side (drives IR/status, consumes control)
// slave : the control unit
interface control_unit_if;
  import control_unit_pkg::*;

  logic [31:0]  IR;
  logic [3:0]   status;
  logic [CUL:0] controlWord;
  logic [31:0]  k;

  modport master (output IR, output status, input controlWord, input k);
  modport slave  (input IR, input status, output controlWord, output k);
endinterface

// File: rtl/control_unit_dp_reg_decoder.sv
// Decoder for the register-register data-processing class.
//   opcode  in   IR[31:21]
//   fs      out  ALU function select
//   sl      out  load status flags (S forms)
//   valid   out  opcode belongs to this class
module dp_reg_decoder
  import control_unit_pkg::*;
(
  input  logic [10:0] opcode,
  output logic [4:0]  fs,
  output logic        sl,
  output logic        valid
);

  // NOTE: every output gets a default before the case so no path leaves
  // a signal unassigned; otherwise synthesis infers a latch.
  always_comb begin
    fs    = FS_AND;
    sl    = 1'b0;
    valid = 1'b1;
    case (opcode)
      OP_ADD:  fs = FS_ADD;
      OP_ADDS: begin fs = FS_ADD; sl = 1'b1; end
      OP_SUB:  fs = FS_SUB;
      OP_SUBS: begin fs = FS_SUB; sl = 1'b1; end
      OP_AND:  fs = FS_AND;
      OP_ANDS: begin fs = FS_AND; sl = 1'b1; end
      OP_ORR:  fs = FS_ORR;
      OP_EOR:  fs = FS_EOR;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: FETCH/EXECUTE sequencer plus per-class
// instruction decode. Outputs are combinational from state, IR and status.
//   clock  system clock, rising edge
//   reset  asynchronous, active-high; also forces outputs to zero
//   bus    control_unit_if.slave (IR, status in; controlWord, k out)
module control_unit
  import control_unit_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  control_unit_if.slave bus
);

  state_t     state, state_next;
  ctrl_word_t cw;
  k_sel_t     k_sel;
  logic [31:0] k_val;

  logic [31:0] ir;
  logic [4:0]  rd, rn, rm;
  logic [4:0]  dp_fs;
  logic        dp_sl, dp_valid;
  logic        is_dpi;

  assign ir = bus.IR;
  assign rd = ir[4:0];
  assign rn = ir[9:5];
  assign rm = ir[20:16];

  assign is_dpi = (ir[31:22] == OP_ADDI)  || (ir[31:22] == OP_ADDIS) ||
                  (ir[31:22] == OP_SUBI)  || (ir[31:22] == OP_SUBIS);

  dp_reg_decoder u_dp_reg_decoder (
    .opcode (ir[31:21]),
    .fs     (dp_fs),
    .sl     (dp_sl),
    .valid  (dp_valid)
  );

  // NOTE: sequential state uses non-blocking assignment so every flop
  // samples the pre-edge value of its inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    cw         = '0;
    k_sel      = K_ZERO;
    state_next = S_FETCH;  // also recovers from illegal state codes
    case (state)
      S_FETCH: begin
        cw.ps      = PS_INC;
        cw.pc_sel  = 1'b1;
        cw.en_ram  = 1'b1;
        cw.ir_load = 1'b1;
        state_next = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (dp_valid) begin
          cw.da     = rd;
          cw.sa     = rn;
          cw.sb     = rm;
          cw.fs     = dp_fs;
          cw.sl     = dp_sl;
          cw.reg_w  = 1'b1;
          cw.en_alu = 1'b1;
        end else if (is_dpi) begin
          // IR[30] separates SUB from ADD, IR[29] marks the flag-setting form.
          cw.da     = rd;
          cw.sa     = rn;
          cw.fs     = ir[30] ? FS_SUB : FS_ADD;
          cw.sl     = ir[29];
          cw.b_sel  = 1'b1;
          cw.reg_w  = 1'b1;
          cw.en_alu = 1'b1;
          k_sel     = K_IMM12;
        end else if (ir[31:23] == OP_MOVZ) begin
          cw.da     = rd;
          cw.fs     = FS_PASSB;
          cw.b_sel  = 1'b1;
          cw.reg_w  = 1'b1;
          cw.en_alu = 1'b1;
          k_sel     = K_MOVW;
        end else if (ir[31:21] == OP_LDUR) begin
          cw.da     = rd;
          cw.sa     = rn;
          cw.fs     = FS_ADD;
          cw.b_sel  = 1'b1;
          cw.en_ram = 1'b1;
          cw.reg_w  = 1'b1;
          k_sel     = K_IMM9;
        end else if (ir[31:21] == OP_STUR) begin
          cw.sa     = rn;
          cw.sb     = rd;
          cw.fs     = FS_ADD;
          cw.b_sel  = 1'b1;
          cw.ram_w  = 1'b1;
          k_sel     = K_IMM9;
        end else if (ir[31:26] == OP_B) begin
          cw.ps     = PS_REL;
          k_sel     = K_IMM26;
        end else if (ir[31:21] == OP_BR) begin
          cw.ps     = PS_REG;
          cw.sa     = rn;
        end else if (ir[31:24] == OP_BCOND) begin
          cw.ps     = cond_holds(ir[3:0], bus.status) ? PS_REL : PS_HOLD;
          k_sel     = K_IMM19;
        end
      end
      default: ;
    endcase
  end

  // Branch offsets subtract 4 because FETCH has already advanced the PC.
  always_comb begin
    case (k_sel)
      K_IMM12: k_val = {20'd0, ir[21:10]};
      K_IMM9:  k_val = {{23{ir[20]}}, ir[20:12]};
      K_IMM26: k_val = {{4{ir[25]}}, ir[25:0], 2'b00} - 32'd4;
      K_IMM19: k_val = {{11{ir[23]}}, ir[23:5], 2'b00} - 32'd4;
      K_MOVW:  k_val = {16'd0, ir[20:5]} << {ir[22:21], 4'b0000};
      default: k_val = 32'd0;
    endcase
  end

  assign bus.controlWord = reset ? '0    : cw;
  assign bus.k           = reset ? 32'd0 : k_val;

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit. Each vector is applied in a
// FETCH cycle; the FETCH word and the following EXECUTE word are checked
// against hand-computed values.
module tb_control_unit;

  logic clock;
  logic reset;

  control_unit_if bus ();

  control_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Flag byte in word order: RegW RAMW EN_RAM EN_ALU Bsel PCsel SL IRload.
  localparam logic [7:0] F_REGW   = 8'b1000_0000;
  localparam logic [7:0] F_RAMW   = 8'b0100_0000;
  localparam logic [7:0] F_ENRAM  = 8'b0010_0000;
  localparam logic [7:0] F_ENALU  = 8'b0001_0000;
  localparam logic [7:0] F_BSEL   = 8'b0000_1000;
  localparam logic [7:0] F_PCSEL  = 8'b0000_0100;
  localparam logic [7:0] F_SL     = 8'b0000_0010;
  localparam logic [7:0] F_IRLOAD = 8'b0000_0001;

  localparam logic [4:0] T_AND = 5'b00000, T_ORR = 5'b00100, T_ADD = 5'b01000;
  localparam logic [4:0] T_SUB = 5'b01001, T_PASSB = 5'b10100;

  localparam logic [36:0] FETCH_CW = 37'h8_0000_1280;

  function automatic logic [36:0] cw_of(input logic [1:0] ps, input logic [4:0] da,
                                        input logic [4:0] sa, input logic [4:0] sb,
                                        input logic [4:0] fs, input logic [7:0] fl);
    return {ps, da, sa, sb, fs, fl, 7'b0};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply at a negedge in FETCH, check FETCH outputs, then EXECUTE outputs
  // at the next negedge.
  task automatic run_vec(input string name, input logic [31:0] ir, input logic [3:0] st,
                         input logic [36:0] exp_cw, input logic [31:0] exp_k);
    @(negedge clock);
    bus.IR = ir;
    bus.status = st;
    #1;
    check({name, "_fetch_cw"}, 64'(bus.controlWord), 64'(FETCH_CW));
    check({name, "_fetch_k"},  64'(bus.k), 64'd0);
    @(negedge clock);
    #1;
    check({name, "_exec_cw"}, 64'(bus.controlWord), 64'(exp_cw));
    check({name, "_exec_k"},  64'(bus.k), 64'(exp_k));
  endtask

  initial begin
    reset = 1'b1;
    bus.IR = 32'hAA01_0002;
    bus.status = 4'b0000;
    #3;
    check("reset_cw", 64'(bus.controlWord), 64'd0);
    check("reset_k",  64'(bus.k), 64'd0);

    // Release between edges: FETCH word must appear at once.
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("post_reset_fetch_cw", 64'(bus.controlWord), 64'(FETCH_CW));
    check("fetch_cw_pack", 64'(cw_of(2'b01, 0, 0, 0, 0, F_ENRAM | F_PCSEL | F_IRLOAD)),
          64'(bus.controlWord));
    check("post_reset_fetch_k", 64'(bus.k), 64'd0);

    // ORR X2,X0,X1 in EXECUTE.
    @(negedge clock);
    #1;
    check("orr_exec_cw", 64'(bus.controlWord),
          64'(cw_of(2'b00, 5'd2, 5'd0, 5'd1, T_ORR, F_REGW | F_ENALU)));
    check("orr_exec_k", 64'(bus.k), 64'd0);

    // Reset mid-EXECUTE: outputs zero, then FETCH after release.
    #1 reset = 1'b1;
    #1;
    check("mid_reset_cw", 64'(bus.controlWord), 64'd0);
    check("mid_reset_k",  64'(bus.k), 64'd0);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("abort_fetch_cw", 64'(bus.controlWord), 64'(FETCH_CW));

    run_vec("orr", 32'hAA01_0002, 4'b0000,
            cw_of(2'b00, 5'd2, 5'd0, 5'd1, T_ORR, F_REGW | F_ENALU), 32'd0);
    run_vec("addi", 32'h9100_1483, 4'b0000,
            cw_of(2'b00, 5'd3, 5'd4, 5'd0, T_ADD, F_REGW | F_ENALU | F_BSEL), 32'd5);
    run_vec("subs", {11'b11101011000, 5'd7, 6'd0, 5'd6, 5'd5}, 4'b0000,
            cw_of(2'b00, 5'd5, 5'd6, 5'd7, T_SUB, F_REGW | F_ENALU | F_SL), 32'd0);
    run_vec("ands", {11'b11101010000, 5'd3, 6'd0, 5'd8, 5'd9}, 4'b0000,
            cw_of(2'b00, 5'd9, 5'd8, 5'd3, T_AND, F_REGW | F_ENALU | F_SL), 32'd0);
    run_vec("addis_max", {10'b1011000100, 12'hFFF, 5'd2, 5'd1}, 4'b0000,
            cw_of(2'b00, 5'd1, 5'd2, 5'd0, T_ADD, F_REGW | F_ENALU | F_BSEL | F_SL), 32'h0000_0FFF);
    run_vec("movz_hw1", {9'b110100101, 2'd1, 16'h1234, 5'd1}, 4'b0000,
            cw_of(2'b00, 5'd1, 5'd0, 5'd0, T_PASSB, F_REGW | F_ENALU | F_BSEL), 32'h1234_0000);
    run_vec("ldur_neg", {11'b11111000010, 9'h1F8, 2'b00, 5'd10, 5'd9}, 4'b0000,
            cw_of(2'b00, 5'd9, 5'd10, 5'd0, T_ADD, F_REGW | F_ENRAM | F_BSEL), 32'hFFFF_FFF8);
    run_vec("stur", {11'b11111000000, 9'd16, 2'b00, 5'd12, 5'd11}, 4'b0000,
            cw_of(2'b00, 5'd0, 5'd12, 5'd11, T_ADD, F_RAMW | F_BSEL), 32'd16);
    run_vec("b_back", {6'b000101, 26'h3FF_FFFF}, 4'b0000,
            cw_of(2'b11, 0, 0, 0, 0, 8'h00), 32'hFFFF_FFF8);
    run_vec("b_fwd", {6'b000101, 26'd3}, 4'b0000,
            cw_of(2'b11, 0, 0, 0, 0, 8'h00), 32'd8);
    run_vec("br", {11'b11010110000, 5'b11111, 6'd0, 5'd30, 5'd0}, 4'b0000,
            cw_of(2'b10, 5'd0, 5'd30, 0, 0, 8'h00), 32'd0);
    run_vec("beq_taken", 32'h5400_0040, 4'b0100,
            cw_of(2'b11, 0, 0, 0, 0, 8'h00), 32'd4);
    run_vec("beq_not", 32'h5400_0040, 4'b0000, 37'd0, 32'd4);
    run_vec("bne_not", {8'h54, 19'd2, 1'b0, 4'b0001}, 4'b0100, 37'd0, 32'd4);
    run_vec("bgt_taken", {8'h54, 19'h7FFFF, 1'b0, 4'b1100}, 4'b1001,
            cw_of(2'b11, 0, 0, 0, 0, 8'h00), 32'hFFFF_FFF8);
    run_vec("blt_taken", {8'h54, 19'd1, 1'b0, 4'b1011}, 4'b1000,
            cw_of(2'b11, 0, 0, 0, 0, 8'h00), 32'd0);
    run_vec("ble_not", {8'h54, 19'd1, 1'b0, 4'b1101}, 4'b0000, 37'd0, 32'd0);
    run_vec("never", {8'h54, 19'd1, 1'b0, 4'b1000}, 4'b1111, 37'd0, 32'd0);
    run_vec("always", {8'h54, 19'd1, 1'b0, 4'b1111}, 4'b0000,
            cw_of(2'b11, 0, 0, 0, 0, 8'h00), 32'd0);
    run_vec("unknown", 32'hFFFF_FFFF, 4'b0000, 37'd0, 32'd0);
    run_vec("after_nop", 32'h9100_1483, 4'b0000,
            cw_of(2'b00, 5'd3, 5'd4, 5'd0, T_ADD, F_REGW | F_ENALU | F_BSEL), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
